fmap_channel_collector: RTL
===========================

Name: fmap_channel_collector

Overview:
- Upstream stage of the max-pooling block.
- Accepts the convolution output as a serial stream: one DATA_BITS word per handshake, raster order within a channel, channels in sequence.
- Packs each channel into a flat H*W frame register and presents it, with a handshake, to the single-channel max-pooling input.
- Tracks channel index and flags the last channel of a feature map (D channels).

Parameters:
- DATA_BITS, 32, width of one feature element (two's-complement signed).
- D, 32, channels per feature map.
- H, 46, frame height; must be even.
- W, 46, frame width; must be even.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in_data  input  DATA_BITS  streamed element.
- in_valid  input  1  in_data valid.
- in_ready  output  1  collector accepts in_data this cycle.
- frame_data  output  H*W*DATA_BITS  packed channel frame; element idx = r*W+c at bits [idx*DATA_BITS +: DATA_BITS] (element 0 in LSBs).
- frame_valid  output  1  frame_data complete and stable.
- frame_ready  input  1  downstream consumes frame.
- frame_channel  output  clog2(D)  channel index of presented frame.
- frame_last  output  1  presented frame is channel D-1.

Behaviour:
- One clock domain. Reset is asynchronous and active-low.
- Reset values:
  - state = FILL.
  - elem_cnt = 0, ch_cnt = 0.
  - frame_data = 0.
  - frame_valid = 0, in_ready = 1.
  - frame_channel = 0, frame_last = 0.
- Accept = in_valid && in_ready. Registered on the rising edge into slot elem_cnt.
- State FILL:
  - in_ready = 1.
  - On accept with elem_cnt < H*W-1: store the element, then elem_cnt++.
  - On accept with elem_cnt == H*W-1: store the element, set elem_cnt = 0 and go to HOLD.
  - frame_valid rises the cycle after the final accept, so latency is 1 cycle from the last element.
- State HOLD:
  - in_ready = 0, frame_valid = 1.
  - frame_data, frame_channel and frame_last are held stable.
  - On frame_ready: go to FILL. ch_cnt = (ch_cnt == D-1) ? 0 : ch_cnt+1. frame_valid drops on the next cycle.
- Handshake rules:
  - Acceptance has no combinational path from frame_ready to in_ready. in_ready is a function of state only.
  - Minimum channel period is H*W+1 cycles.
  - frame_ready is ignored in FILL.
  - in_valid is ignored in HOLD; the producer must hold its data.
- frame_data is not cleared between channels. Every slot is overwritten before frame_valid reasserts.
- frame_last = frame_valid && (ch_cnt == D-1).
- Wrap-around: after channel D-1 is consumed, ch_cnt returns to 0 with no idle cycle.
- Reset mid-operation (any state): all counters and outputs return to reset values immediately. A partial frame is discarded.
- in_data is stored bit-exact unless RELU_COLLECT_EN is defined.

Optional Feature:
- Macro: RELU_COLLECT_EN.
- Defined:
  - Each accepted element is stored as (in_data[DATA_BITS-1] ? 0 : in_data), i.e. ReLU fused at capture.
  - Timing and handshake are unchanged.
- Undefined: elements are stored unmodified.

Decomposition:
- Shared package (cnn_pkg): DATA_BITS default, D/H/W defaults, the CH_W = clog2(D) and ELEM_W = clog2(H*W) width constants, and the collector state encoding (FILL=0, HOLD=1).
- One natural sub-module, fmap_elem_writer: decodes elem_cnt into a per-slot write enable and applies optional ReLU. The top module holds the FSM, counters and handshake.

Test Plan:
All scenarios use bench params DATA_BITS=8, H=W=4, D=2 unless noted.
- Fill channel 0: stream 16 values 0x01..0x10 with in_valid held high and frame_ready=0. Required: in_ready=1 for 16 cycles. frame_valid=1 from the next cycle. frame_data = {0x10,...,0x01} with 0x01 in bits[7:0]. frame_channel=0, frame_last=0. in_ready=0 while held.
- Backpressure: hold frame_ready=0 for 20 cycles while in_valid=1 with a new value. Required: frame_data unchanged, no element accepted. Pulse frame_ready: FILL resumes and the first new value lands in slot 0.
- Last/wrap: complete channel 1. Required: frame_channel=1, frame_last=1. After frame_ready, the next frame reports frame_channel=0, frame_last=0.
- Gapped input: toggle in_valid every cycle. Required: frame_valid only after the 16th accepted word, and slot order preserved.
- Async reset: drop reset_n after 7 accepts with no clock edge needed. Required: frame_valid=0, in_ready=1, frame_channel=0. The next 16 words form a full fresh frame.
- RELU_COLLECT_EN defined: stream 0x80, 0xFF, 0x7F, 0x00, ... Required: slots 0,1 = 0x00, slot 2 = 0x7F. Without the macro, 0x80 and 0xFF are stored unchanged.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared constants, width helpers and collector state encoding for the CNN pooling front end.
package cnn_pkg;

  localparam int DATA_BITS_DEF = 32;
  localparam int D_DEF         = 32;
  localparam int H_DEF         = 46;
  localparam int W_DEF         = 46;

  // Width of a counter over n values; never below one bit so D=1 or H*W=1 still elaborate.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CH_W   = clog2_min1(D_DEF);
  localparam int ELEM_W = clog2_min1(H_DEF * W_DEF);

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } coll_state_e;

endpackage

// File: rtl/fmap_elem_writer.sv
// Decodes the element index into a one-hot slot write enable and conditions the write data.
// Purely combinational; with RELU_COLLECT_EN defined, negative elements are captured as zero.
module fmap_elem_writer
  import cnn_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int NUM_ELEM  = H_DEF * W_DEF,
  parameter int EW        = clog2_min1(NUM_ELEM)
) (
  input  logic                 i_wr_en,
  input  logic [EW-1:0]        i_elem_idx,
  input  logic [DATA_BITS-1:0] i_data,
  output logic [NUM_ELEM-1:0]  o_slot_we,
  output logic [DATA_BITS-1:0] o_wr_data
);

  for (genvar g = 0; g < NUM_ELEM; g++) begin : g_we
    assign o_slot_we[g] = i_wr_en && (i_elem_idx == EW'(g));
  end

`ifdef RELU_COLLECT_EN
  assign o_wr_data = i_data[DATA_BITS-1] ? '0 : i_data;
`else
  assign o_wr_data = i_data;
`endif

endmodule

// File: rtl/fmap_channel_collector.sv
// Packs a serial raster stream into one H*W frame per channel; frame_valid 1 cycle after the last word.
// in_ready depends only on state (low while a frame is held); optional RELU_COLLECT_EN clamps negatives.
module fmap_channel_collector
  import cnn_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int D         = D_DEF,
  parameter int H         = H_DEF,
  parameter int W         = W_DEF
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [DATA_BITS-1:0]         in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [H*W*DATA_BITS-1:0]     frame_data,
  output logic                         frame_valid,
  input  logic                         frame_ready,
  output logic [clog2_min1(D)-1:0]     frame_channel,
  output logic                         frame_last
);

  localparam int NUM_ELEM = H * W;
  localparam int EW       = clog2_min1(NUM_ELEM);
  localparam int CW       = clog2_min1(D);

  coll_state_e          r_state;
  coll_state_e          w_state_nxt;
  logic [EW-1:0]        r_elem_cnt;
  logic [CW-1:0]        r_ch_cnt;
  logic                 w_accept;
  logic                 w_last_elem;
  logic                 w_consume;
  logic [NUM_ELEM-1:0]  w_slot_we;
  logic [DATA_BITS-1:0] w_wr_data;
  logic [DATA_BITS-1:0] r_frame [NUM_ELEM];

  assign w_accept    = in_valid && in_ready;
  assign w_last_elem = (r_elem_cnt == EW'(NUM_ELEM - 1));
  assign w_consume   = (r_state == ST_HOLD) && frame_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_FILL;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_FILL: if (w_accept && w_last_elem) w_state_nxt = ST_HOLD;
      ST_HOLD: if (frame_ready)             w_state_nxt = ST_FILL;
    endcase
  end

  always_comb begin
    in_ready    = 1'b0;
    frame_valid = 1'b0;
    case (r_state)
      ST_FILL: in_ready    = 1'b1;
      ST_HOLD: frame_valid = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_elem_cnt <= '0;
    end else if (w_accept) begin
      r_elem_cnt <= w_last_elem ? '0 : r_elem_cnt + EW'(1);
    end
  end

  // Channel index advances only when the held frame is handed off, wrapping to 0 after D-1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ch_cnt <= '0;
    end else if (w_consume) begin
      r_ch_cnt <= (r_ch_cnt == CW'(D - 1)) ? '0 : r_ch_cnt + CW'(1);
    end
  end

  fmap_elem_writer #(
    .DATA_BITS (DATA_BITS),
    .NUM_ELEM  (NUM_ELEM),
    .EW        (EW)
  ) u_elem_writer (
    .i_wr_en    (w_accept),
    .i_elem_idx (r_elem_cnt),
    .i_data     (in_data),
    .o_slot_we  (w_slot_we),
    .o_wr_data  (w_wr_data)
  );

  // Slots are never cleared between channels; every one is rewritten before the next HOLD.
  for (genvar g = 0; g < NUM_ELEM; g++) begin : g_slot
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)          r_frame[g] <= '0;
      else if (w_slot_we[g]) r_frame[g] <= w_wr_data;
    end
    assign frame_data[g*DATA_BITS +: DATA_BITS] = r_frame[g];
  end

  assign frame_channel = r_ch_cnt;
  assign frame_last    = frame_valid && (r_ch_cnt == CW'(D - 1));

endmodule
